// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage.
package wb_pkg;

    // Load type encodings carried in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Result source indices on the packed source bus
    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_PC4  = 2;
    localparam int SRC_CSR  = 3;

    // The source slot that is replaced by aligned load data
    localparam int DEFAULT_LOAD_SLOT = SRC_LOAD;

    // Writeback slot occupancy
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        WAIT  = 2'b01,
        HOLD  = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Aligns a raw data-memory word to the addressed byte/half/word and extends it.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    // Shift the addressed bytes down to bit 0, then extend by load type
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        result  = '0;
        case (funct3)
            F3_LB:   result = XLEN'($signed(shifted[7:0]));
            F3_LH:   result = XLEN'($signed(shifted[15:0]));
            F3_LW:   result = XLEN'($signed(shifted[31:0]));
            F3_LBU:  result = XLEN'(shifted[7:0]);
            F3_LHU:  result = XLEN'(shifted[15:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// One-entry handshaked writeback slot: selects the result, waits for load
// data, drives the register-file write port and counts retirements.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NSRC      = 4,
    parameter int LOAD_SLOT = DEFAULT_LOAD_SLOT,
    parameter int SELW      = $clog2(NSRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [SELW-1:0]      m_sel,
    input  logic [NSRC*XLEN-1:0] m_srcs,
    input  logic [4:0]           m_rd,
    input  logic                 m_reg_write,
    input  logic                 m_is_load,
    input  logic [2:0]           m_funct3,
    input  logic [1:0]           m_addr_lo,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 wb_busy,
    output logic                 retire,
    output logic [63:0]          instret
);

    wb_state_e       state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            rf_we_q, rf_we_d;
    logic            retire_q, retire_d;
    logic            busy_q, busy_d;
    logic [63:0]     instret_q, instret_d;

    logic [XLEN-1:0] sel_result;
    logic [XLEN-1:0] load_result;
    logic            accept;

    // Load data is aligned with the funct3/offset captured at acceptance
    load_align #(.XLEN(XLEN)) u_align (
        .rdata   (dmem_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .result  (load_result)
    );

    assign m_ready = (state_q != WAIT);
    assign accept  = m_valid && m_ready;

    // Source mux: out-of-range indices and the load slot yield zero for non-loads
    always_comb begin
        sel_result = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (m_sel == SELW'(i) && i != LOAD_SLOT) begin
                sel_result = m_srcs[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state and next-output logic; all outputs but m_ready come from flops
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        result_d    = result_q;
        case (state_q)
            EMPTY, HOLD: begin
                if (accept) begin
                    rd_d        = m_rd;
                    reg_write_d = m_reg_write;
                    funct3_d    = m_funct3;
                    addr_lo_d   = m_addr_lo;
                    if (m_is_load) begin
                        state_d = WAIT;
                    end else begin
                        result_d = sel_result;
                        state_d  = HOLD;
                    end
                end else begin
                    state_d = EMPTY;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    result_d = load_result;
                    state_d  = HOLD;
                end
            end
            default: state_d = EMPTY;
        endcase
        retire_d  = (state_d == HOLD);
        busy_d    = (state_d == WAIT);
        rf_we_d   = retire_d && reg_write_d && (rd_d != 5'd0);
        instret_d = instret_q + 64'(retire_d);
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            result_q    <= '0;
            rf_we_q     <= 1'b0;
            retire_q    <= 1'b0;
            busy_q      <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            result_q    <= result_d;
            rf_we_q     <= rf_we_d;
            retire_q    <= retire_d;
            busy_q      <= busy_d;
            instret_q   <= instret_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rd_q;
    assign rf_wdata = result_q;
    assign retire   = retire_q;
    assign wb_busy  = busy_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with hand-computed expected values.
module tb_wb_stage;

    localparam int XLEN = 32;
    localparam int NSRC = 4;
    localparam int SELW = 3;

    logic                 clk;
    logic                 rst;
    logic                 m_valid;
    logic                 m_ready;
    logic [SELW-1:0]      m_sel;
    logic [NSRC*XLEN-1:0] m_srcs;
    logic [4:0]           m_rd;
    logic                 m_reg_write;
    logic                 m_is_load;
    logic [2:0]           m_funct3;
    logic [1:0]           m_addr_lo;
    logic                 dmem_rvalid;
    logic [XLEN-1:0]      dmem_rdata;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 wb_busy;
    logic                 retire;
    logic [63:0]          instret;

    int checkCount = 0;
    int errorCount = 0;

    wb_stage #(.XLEN(XLEN), .NSRC(NSRC), .LOAD_SLOT(1), .SELW(SELW)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sel       (m_sel),
        .m_srcs      (m_srcs),
        .m_rd        (m_rd),
        .m_reg_write (m_reg_write),
        .m_is_load   (m_is_load),
        .m_funct3    (m_funct3),
        .m_addr_lo   (m_addr_lo),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .wb_busy     (wb_busy),
        .retire      (retire),
        .instret     (instret)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it differs
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction from the memory stage
    task automatic applyStimulus(input logic valid, input logic [SELW-1:0] sel, input logic [4:0] rd,
                                 input logic rw, input logic isLoad, input logic [2:0] f3,
                                 input logic [1:0] addrLo);
        m_valid     = valid;
        m_sel       = sel;
        m_rd        = rd;
        m_reg_write = rw;
        m_is_load   = isLoad;
        m_funct3    = f3;
        m_addr_lo   = addrLo;
    endtask

    // Issue a load, return data after 'gap' idle WAIT cycles, check the write
    task automatic runLoad(input string tag, input logic [2:0] f3, input logic [1:0] addrLo,
                           input logic [4:0] rd, input logic [31:0] rdata, input int gap,
                           input logic [31:0] expected);
        applyStimulus(1'b1, 3'd0, rd, 1'b1, 1'b1, f3, addrLo);
        stepClk();
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        checkOutput({tag, "_ready_wait"}, 64'(m_ready), 64'd0);
        checkOutput({tag, "_busy_wait"}, 64'(wb_busy), 64'd1);
        for (int i = 0; i < gap; i++) begin
            stepClk();
            checkOutput({tag, "_we_wait"}, 64'(rf_we), 64'd0);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        stepClk();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'hA5A5_A5A5;
        checkOutput({tag, "_we"}, 64'(rf_we), 64'd1);
        checkOutput({tag, "_waddr"}, 64'(rf_waddr), 64'(rd));
        checkOutput({tag, "_wdata"}, 64'(rf_wdata), 64'(expected));
        checkOutput({tag, "_busy_done"}, 64'(wb_busy), 64'd0);
        stepClk();
        checkOutput({tag, "_we_after"}, 64'(rf_we), 64'd0);
    endtask

    // Hold reset for two edges and release just after an edge
    task automatic resetDut();
        rst = 1'b1;
        stepClk();
        stepClk();
        rst = 1'b0;
    endtask

    // Directed test sequence
    initial begin
        rst         = 1'b1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        m_srcs      = {32'h3333_0000, 32'h2222_0004, 32'hDEAD_BEEF, 32'h0000_1234};
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        #2;
        checkOutput("rst_we", 64'(rf_we), 64'd0);
        checkOutput("rst_waddr", 64'(rf_waddr), 64'd0);
        checkOutput("rst_wdata", 64'(rf_wdata), 64'd0);
        checkOutput("rst_retire", 64'(retire), 64'd0);
        checkOutput("rst_busy", 64'(wb_busy), 64'd0);
        checkOutput("rst_instret", instret, 64'd0);
        checkOutput("rst_ready", 64'(m_ready), 64'd1);
        stepClk();
        stepClk();
        rst = 1'b0;

        // Single ALU op
        applyStimulus(1'b1, 3'd0, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        checkOutput("alu_we", 64'(rf_we), 64'd1);
        checkOutput("alu_waddr", 64'(rf_waddr), 64'd5);
        checkOutput("alu_wdata", 64'(rf_wdata), 64'h1234);
        checkOutput("alu_retire", 64'(retire), 64'd1);
        stepClk();
        checkOutput("alu_we_off", 64'(rf_we), 64'd0);
        checkOutput("alu_retire_off", 64'(retire), 64'd0);
        checkOutput("alu_instret", instret, 64'd1);

        // Loads of each width and extension
        runLoad("lb", 3'b000, 2'd3, 5'd7, 32'h80FF_FFFF, 1, 32'hFFFF_FF80);
        checkOutput("lb_instret", instret, 64'd2);
        runLoad("lhu", 3'b101, 2'd2, 5'd8, 32'hBEEF_0000, 0, 32'h0000_BEEF);
        runLoad("lh", 3'b001, 2'd2, 5'd8, 32'hBEEF_0000, 2, 32'hFFFF_BEEF);
        runLoad("lw", 3'b010, 2'd0, 5'd11, 32'h1234_5678, 1, 32'h1234_5678);
        runLoad("lbu", 3'b100, 2'd1, 5'd12, 32'h0000_8000, 1, 32'h0000_0080);
        runLoad("lbad", 3'b011, 2'd0, 5'd13, 32'hFFFF_FFFF, 1, 32'h0000_0000);
        checkOutput("loads_instret", instret, 64'd7);

        // Four back-to-back non-loads, rd=0 on the third
        resetDut();
        applyStimulus(1'b1, 3'd0, 5'd1, 1'b1, 1'b0, 3'd0, 2'd0);
        stepClk();
        checkOutput("b2b0_retire", 64'(retire), 64'd1);
        checkOutput("b2b0_we", 64'(rf_we), 64'd1);
        checkOutput("b2b0_wdata", 64'(rf_wdata), 64'h0000_1234);
        applyStimulus(1'b1, 3'd2, 5'd2, 1'b1, 1'b0, 3'd0, 2'd0);
        stepClk();
        checkOutput("b2b1_retire", 64'(retire), 64'd1);
        checkOutput("b2b1_we", 64'(rf_we), 64'd1);
        checkOutput("b2b1_wdata", 64'(rf_wdata), 64'h2222_0004);
        applyStimulus(1'b1, 3'd3, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0);
        stepClk();
        checkOutput("b2b2_retire", 64'(retire), 64'd1);
        checkOutput("b2b2_we", 64'(rf_we), 64'd0);
        checkOutput("b2b2_wdata", 64'(rf_wdata), 64'h3333_0000);
        applyStimulus(1'b1, 3'd2, 5'd4, 1'b1, 1'b0, 3'd0, 2'd0);
        stepClk();
        checkOutput("b2b3_retire", 64'(retire), 64'd1);
        checkOutput("b2b3_we", 64'(rf_we), 64'd1);
        checkOutput("b2b3_waddr", 64'(rf_waddr), 64'd4);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        stepClk();
        checkOutput("b2b_retire_off", 64'(retire), 64'd0);
        checkOutput("b2b_instret", instret, 64'd4);

        // Out-of-range select and the load slot on a non-load both give zero
        applyStimulus(1'b1, 3'd4, 5'd9, 1'b1, 1'b0, 3'd0, 2'd0);
        stepClk();
        checkOutput("oor_we", 64'(rf_we), 64'd1);
        checkOutput("oor_wdata", 64'(rf_wdata), 64'd0);
        applyStimulus(1'b1, 3'd1, 5'd10, 1'b1, 1'b0, 3'd0, 2'd0);
        stepClk();
        checkOutput("ldslot_waddr", 64'(rf_waddr), 64'd10);
        checkOutput("ldslot_wdata", 64'(rf_wdata), 64'd0);
        applyStimulus(1'b1, 3'd2, 5'd14, 1'b0, 1'b0, 3'd0, 2'd0);
        stepClk();
        checkOutput("norw_we", 64'(rf_we), 64'd0);
        checkOutput("norw_retire", 64'(retire), 64'd1);
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        stepClk();

        // Stray rvalid while empty
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        stepClk();
        dmem_rvalid = 1'b0;
        checkOutput("stray_we", 64'(rf_we), 64'd0);
        checkOutput("stray_retire", 64'(retire), 64'd0);
        checkOutput("stray_busy", 64'(wb_busy), 64'd0);
        checkOutput("stray_instret", instret, 64'd7);

        // Reset during WAIT drops the pending load
        applyStimulus(1'b1, 3'd0, 5'd15, 1'b1, 1'b1, 3'b010, 2'd0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        checkOutput("rw_busy", 64'(wb_busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rw_ready_rst", 64'(m_ready), 64'd1);
        checkOutput("rw_busy_rst", 64'(wb_busy), 64'd0);
        checkOutput("rw_instret_rst", instret, 64'd0);
        #1;
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_7777;
        stepClk();
        dmem_rvalid = 1'b0;
        checkOutput("rw_we", 64'(rf_we), 64'd0);
        checkOutput("rw_retire", 64'(retire), 64'd0);
        checkOutput("rw_instret", instret, 64'd0);
        checkOutput("rw_ready", 64'(m_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised writeback stage for the 32-bit RISC-V pipeline. It registers one instruction from the memory stage and selects its result from NSRC packed sources. It holds loads until data memory returns read data, then aligns and sign/zero-extends that data. It drives the register-file write port and forwarding bus, and counts retired instructions. It replaces the purely combinational result mux with a one-entry, handshaked pipeline slot.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)
- NSRC, 4, number of result sources on m_srcs
- LOAD_SLOT, 1, source index replaced by aligned load data
- SELW, $clog2(NSRC), width of m_sel

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m_valid  in  1  memory stage presents an instruction
- m_ready  out  1  stage can accept; transfer when m_valid && m_ready
- m_sel  in  SELW  result source index
- m_srcs  in  NSRC*XLEN  packed sources, slot i = bits [i*XLEN +: XLEN]
- m_rd  in  5  destination register
- m_reg_write  in  1  instruction writes rd
- m_is_load  in  1  result comes from data memory
- m_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- m_addr_lo  in  2  byte offset of load address
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  raw word from data memory
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data; the forwarding bus uses the same three signals
- wb_busy  out  1  load outstanding (hazard unit stalls upstream)
- retire  out  1  one instruction retires this cycle
- instret  out  64  retired-instruction counter

## Operation
- State machine states:
  - EMPTY: no entry held.
  - WAIT: load accepted, data not yet returned.
  - HOLD: entry complete and retiring this cycle.
- Transitions:
  - Accepting a non-load goes to HOLD.
  - Accepting a load goes to WAIT.
  - In WAIT, dmem_rvalid=1 latches the aligned data and goes to HOLD.
  - In HOLD with no accept, go to EMPTY.
  - In HOLD with an accept, go to HOLD or WAIT according to the new instruction.
- m_ready = (state != WAIT). Back-to-back non-loads are accepted every cycle.
- Result on capture for a non-load:
  - m_sel < NSRC and m_sel != LOAD_SLOT: the selected slot.
  - m_sel >= NSRC: zero.
  - m_sel == LOAD_SLOT with m_is_load=0: zero.
- Load alignment:
  - Shift dmem_rdata right by m_addr_lo*8.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - LW passes the low 32 bits, sign-extended when XLEN=64.
  - Other funct3 values produce zero.
- rf_we = HOLD && reg_write && rd != 0. Writes to x0 are suppressed but still retire.
- retire = (state == HOLD). instret increments by 1 on each retire and wraps at 2^64-1 -> 0.
- dmem_rvalid outside WAIT is ignored.
- wb_busy = (state == WAIT).

## Timing
- Reset (async, takes effect immediately):
  - State goes to EMPTY.
  - rf_we=0, rf_waddr=0, rf_wdata=0, retire=0, wb_busy=0, instret=0, m_ready=1.
- Non-load latency: accepted at edge N, rf_we high during cycle N+1 for exactly one cycle.
- Load latency: rf_we high in the cycle after the edge that samples dmem_rvalid=1 in WAIT.
- rvalid in the same cycle as load acceptance is not sampled. Data memory returns data no earlier than the cycle after acceptance.
- All outputs except m_ready are driven from registers. m_ready is decoded from state only, with no combinational path from m_valid.
- Reset asserted in WAIT drops the pending load; no write occurs for it.

## Structure
- Shared package wb_pkg holds:
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - State encoding (EMPTY=2'b00, WAIT=2'b01, HOLD=2'b10).
  - Default LOAD_SLOT and the source index names (SRC_ALU=0, SRC_LOAD=1, SRC_PC4=2, SRC_CSR=3).
- One combinational sub-module, load_align (inputs: rdata, funct3, addr_lo; output: XLEN result). The NSRC mux and state machine stay in wb_stage.

## Test plan
- After reset, send ALU op (m_sel=0, slot0=0x0000_1234, rd=5) -> next cycle rf_we=1, waddr=5, wdata=0x1234, instret=1.
- Load LB, addr_lo=3, dmem_rdata=0x80FF_FFFF returned 2 cycles later -> m_ready=0 and wb_busy=1 while waiting; wdata=0xFFFF_FF80 one cycle after rvalid.
- LHU addr_lo=2 with rdata=0xBEEF_0000 -> wdata=0x0000_BEEF; LH same data -> 0xFFFF_BEEF.
- Four back-to-back non-loads (sel 0,2,3,2; rd=0 on the third) -> four retire pulses on consecutive cycles, rf_we low on the third only, instret=4.
- m_sel=NSRC (out of range) -> wdata=0. Stray dmem_rvalid while EMPTY -> no write.
- Assert rst while in WAIT, then drive rvalid -> no rf_we, instret=0, m_ready=1.
